// File: rtl/dice_pkg.sv
// Shared state encoding, craps outcome constants and a face-sum helper
// used by the dice round sequencer.
package dice_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ROLL1 = 3'd1,
        EVAL1 = 3'd2,
        POINT = 3'd3,
        ROLL2 = 3'd4,
        EVAL2 = 3'd5,
        WIN   = 3'd6,
        LOSE  = 3'd7
    } state_t;

    localparam logic [3:0] WIN_A    = 4'd7;
    localparam logic [3:0] WIN_B    = 4'd11;
    localparam logic [3:0] CRAPS_2  = 4'd2;
    localparam logic [3:0] CRAPS_3  = 4'd3;
    localparam logic [3:0] CRAPS_12 = 4'd12;
    localparam logic [3:0] SEVEN    = 4'd7;

    localparam logic [2:0] FACE_MIN = 3'd1;
    localparam logic [2:0] FACE_MAX = 3'd6;

    // Two faces of 1..6 never exceed 12, so 4 bits hold the sum exactly.
    function automatic logic [3:0] face_sum(input logic [2:0] a, input logic [2:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/dice_counter.sv
// One die: a 1..6 wrap counter that steps when enabled and flags the
// 6->1 wrap so a second die can be chained off it.
module dice_counter
    import dice_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    output logic [2:0] o_face,
    output logic       o_wrap
);

    logic [2:0] r_face;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_face <= FACE_MIN;
        end else if (i_en) begin
            r_face <= (r_face == FACE_MAX) ? FACE_MIN : r_face + 3'd1;
        end
    end

    assign o_face = r_face;
    assign o_wrap = i_en && (r_face == FACE_MAX);

endmodule

// File: rtl/dice_round_sequencer.sv
// Craps round sequencer: spins two chained dice while rb is held, evaluates
// the come-out and point rolls. Define DICE_SCORE_EN for win/loss counters.
module dice_round_sequencer
    import dice_pkg::*;
#(
    parameter int SCORE_W = 8
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rb,
    input  logic               new_game,
    output logic [2:0]         die1,
    output logic [2:0]         die2,
    output logic [3:0]         sum,
    output logic [3:0]         point,
    output logic               point_valid,
    output logic               roll_active,
    output logic               win,
    output logic               lose,
    output logic               round_done,
    output logic [SCORE_W-1:0] wins,
    output logic [SCORE_W-1:0] losses,
    output state_t             o_dbg_state,
    output logic               o_dbg_dice_cycle
);

    state_t     r_state;
    state_t     w_next;
    logic       w_rolling;
    logic       w_advance;
    logic       w_wrap1;
    logic       w_wrap2;
    logic       w_done_now;
    logic       w_enter_done;
    logic [2:0] w_die1;
    logic [2:0] w_die2;
    logic [3:0] r_sum;
    logic [3:0] r_point;
    logic       r_point_valid;
    logic       r_roll_active;
    logic       r_win;
    logic       r_lose;
    logic       r_round_done;

    assign w_rolling  = (r_state == ROLL1) || (r_state == ROLL2);
    // An abort in the same cycle freezes the dice rather than spinning them.
    assign w_advance  = w_rolling && rb && !new_game;
    assign w_done_now = (r_state == WIN) || (r_state == LOSE);
    assign w_enter_done = ((w_next == WIN) || (w_next == LOSE)) && !w_done_now;

    dice_counter u_die1 (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_advance),
        .o_face (w_die1),
        .o_wrap (w_wrap1)
    );

    dice_counter u_die2 (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_wrap1),
        .o_face (w_die2),
        .o_wrap (w_wrap2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (new_game) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:  if (rb)  w_next = ROLL1;
                ROLL1: if (!rb) w_next = EVAL1;
                EVAL1: begin
                    if ((r_sum == WIN_A) || (r_sum == WIN_B)) begin
                        w_next = WIN;
                    end else if ((r_sum == CRAPS_2) || (r_sum == CRAPS_3) ||
                                 (r_sum == CRAPS_12)) begin
                        w_next = LOSE;
                    end else begin
                        w_next = POINT;
                    end
                end
                POINT: if (rb)  w_next = ROLL2;
                ROLL2: if (!rb) w_next = EVAL2;
                EVAL2: begin
                    // Making the point wins even when the point itself is 7-free.
                    if (r_sum == r_point) begin
                        w_next = WIN;
                    end else if (r_sum == SEVEN) begin
                        w_next = LOSE;
                    end else begin
                        w_next = POINT;
                    end
                end
                WIN:     w_next = WIN;
                LOSE:    w_next = LOSE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum         <= 4'd0;
            r_point       <= 4'd0;
            r_point_valid <= 1'b0;
            r_roll_active <= 1'b0;
            r_win         <= 1'b0;
            r_lose        <= 1'b0;
            r_round_done  <= 1'b0;
        end else begin
            if (new_game) begin
                r_sum         <= 4'd0;
                r_point       <= 4'd0;
                r_point_valid <= 1'b0;
            end else begin
                if (w_rolling && !rb) begin
                    r_sum <= face_sum(w_die1, w_die2);
                end
                if ((r_state == EVAL1) && (w_next == POINT)) begin
                    r_point       <= r_sum;
                    r_point_valid <= 1'b1;
                end
            end
            // Flags track the state being entered so they line up with it.
            r_roll_active <= (w_next == ROLL1) || (w_next == ROLL2);
            r_win         <= (w_next == WIN);
            r_lose        <= (w_next == LOSE);
            r_round_done  <= w_enter_done;
        end
    end

`ifdef DICE_SCORE_EN
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [SCORE_W-1:0] r_wins;
    logic [SCORE_W-1:0] r_losses;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wins   <= '0;
            r_losses <= '0;
        end else if (w_enter_done) begin
            if ((w_next == WIN) && (r_wins != SCORE_MAX)) begin
                r_wins <= r_wins + 1'b1;
            end
            if ((w_next == LOSE) && (r_losses != SCORE_MAX)) begin
                r_losses <= r_losses + 1'b1;
            end
        end
    end

    assign wins   = r_wins;
    assign losses = r_losses;
`else
    assign wins   = '0;
    assign losses = '0;
`endif

    assign die1             = w_die1;
    assign die2             = w_die2;
    assign sum              = r_sum;
    assign point            = r_point;
    assign point_valid      = r_point_valid;
    assign roll_active      = r_roll_active;
    assign win              = r_win;
    assign lose             = r_lose;
    assign round_done       = r_round_done;
    assign o_dbg_state      = r_state;
    // Marks the cycle the dice pair completes its 36-position period.
    assign o_dbg_dice_cycle = w_wrap2;

endmodule

// File: tb/tb_dice_round_sequencer.sv
// Bench for dice_round_sequencer: directed craps scenarios plus random
// button traffic, every cycle compared against a positional dice model.
module tb_dice_round_sequencer;
    import dice_pkg::*;

    localparam int SCORE_W = 2;
    localparam int SMAX    = (1 << SCORE_W) - 1;
`ifdef DICE_SCORE_EN
    localparam bit SCORE_EN = 1'b1;
`else
    localparam bit SCORE_EN = 1'b0;
`endif

    localparam int P_IDLE  = 0;
    localparam int P_ROLL  = 1;
    localparam int P_EVAL  = 2;
    localparam int P_POINT = 3;
    localparam int P_WIN   = 4;
    localparam int P_LOSE  = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               rb = 1'b0;
    logic               new_game = 1'b0;
    logic [2:0]         die1;
    logic [2:0]         die2;
    logic [3:0]         sum;
    logic [3:0]         point;
    logic               point_valid;
    logic               roll_active;
    logic               win;
    logic               lose;
    logic               round_done;
    logic [SCORE_W-1:0] wins;
    logic [SCORE_W-1:0] losses;
    state_t             dbg_state;
    logic               dbg_dice_cycle;

    int checks = 0;
    int errors = 0;

    // Dice pair as one position 0..35: die1 = pos%6+1, die2 = pos/6+1.
    int m_pos, m_phase, m_sum, m_point, m_wins, m_losses;
    bit m_pv, m_rd;

    dice_round_sequencer #(.SCORE_W(SCORE_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .rb               (rb),
        .new_game         (new_game),
        .die1             (die1),
        .die2             (die2),
        .sum              (sum),
        .point            (point),
        .point_valid      (point_valid),
        .roll_active      (roll_active),
        .win              (win),
        .lose             (lose),
        .round_done       (round_done),
        .wins             (wins),
        .losses           (losses),
        .o_dbg_state      (dbg_state),
        .o_dbg_dice_cycle (dbg_dice_cycle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_phase = P_IDLE; m_sum = 0; m_point = 0; m_pv = 0;
        m_rd = 0; m_wins = 0; m_losses = 0;
    endtask

    task automatic model_finish(input bit is_win);
        m_phase = is_win ? P_WIN : P_LOSE;
        m_rd = 1;
        if (SCORE_EN) begin
            if (is_win && m_wins < SMAX) m_wins++;
            if (!is_win && m_losses < SMAX) m_losses++;
        end
    endtask

    task automatic model_edge(input bit rb_v, input bit ng_v, input bit rs_v);
        m_rd = 0;
        if (rs_v) begin
            model_reset();
        end else if (ng_v) begin
            m_phase = P_IDLE; m_sum = 0; m_point = 0; m_pv = 0;
        end else begin
            case (m_phase)
                P_IDLE:  if (rb_v) m_phase = P_ROLL;
                P_ROLL: begin
                    if (rb_v) begin
                        m_pos = (m_pos + 1) % 36;
                    end else begin
                        m_sum = (m_pos % 6 + 1) + (m_pos / 6 + 1);
                        m_phase = P_EVAL;
                    end
                end
                P_EVAL: begin
                    if (!m_pv) begin
                        if (m_sum == 7 || m_sum == 11) model_finish(1'b1);
                        else if (m_sum == 2 || m_sum == 3 || m_sum == 12) model_finish(1'b0);
                        else begin
                            m_point = m_sum; m_pv = 1; m_phase = P_POINT;
                        end
                    end else begin
                        if (m_sum == m_point) model_finish(1'b1);
                        else if (m_sum == 7) model_finish(1'b0);
                        else m_phase = P_POINT;
                    end
                end
                P_POINT: if (rb_v) m_phase = P_ROLL;
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        chk("die1",        8'(die1),        8'(m_pos % 6 + 1));
        chk("die2",        8'(die2),        8'(m_pos / 6 + 1));
        chk("sum",         8'(sum),         8'(m_sum));
        chk("point",       8'(point),       8'(m_point));
        chk("point_valid", 8'(point_valid), 8'(m_pv));
        chk("roll_active", 8'(roll_active), 8'(m_phase == P_ROLL));
        chk("win",         8'(win),         8'(m_phase == P_WIN));
        chk("lose",        8'(lose),        8'(m_phase == P_LOSE));
        chk("round_done",  8'(round_done),  8'(m_rd));
        chk("wins",        8'(wins),        8'(m_wins));
        chk("losses",      8'(losses),      8'(m_losses));
    endtask

    task automatic cycle(input bit rb_v, input bit ng_v, input bit rs_v);
        rst = rs_v; rb = rb_v; new_game = ng_v;
        @(posedge clk);
        model_edge(rb_v, ng_v, rs_v);
        #1;
        compare_all();
    endtask

    // Hold rb for n cycles, then release it long enough for the outcome to register.
    task automatic roll(input int n);
        repeat (n) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        model_reset();
        do_reset();
        chk("rst_die1", 8'(die1), 8'd1);
        chk("rst_sum",  8'(sum),  8'd0);
        chk("rst_win",  8'(win),  8'd0);

        // Natural seven on the come-out roll; win lands two cycles after release.
        repeat (6) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("nat7_sum",     8'(sum), 8'd7);
        chk("nat7_latency", 8'(win), 8'd0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("nat7_die1",  8'(die1),       8'd6);
        chk("nat7_die2",  8'(die2),       8'd1);
        chk("nat7_win",   8'(win),        8'd1);
        chk("nat7_done",  8'(round_done), 8'd1);
        chk("nat7_wins",  8'(wins),       8'(SCORE_EN ? 1 : 0));
        cycle(1'b0, 1'b0, 1'b0);
        chk("nat7_done_pulse", 8'(round_done), 8'd0);
        chk("nat7_hold",       8'(win),        8'd1);
        cycle(1'b0, 1'b1, 1'b0);
        chk("ng_sum_clear", 8'(sum),  8'd0);
        chk("ng_die_hold",  8'(die1), 8'd6);

        // Snake eyes.
        do_reset();
        roll(1);
        chk("craps2_sum",    8'(sum),    8'd2);
        chk("craps2_lose",   8'(lose),   8'd1);
        chk("craps2_losses", 8'(losses), 8'(SCORE_EN ? 1 : 0));

        // Point 4, miss with 5, then seven out.
        do_reset();
        roll(3);
        chk("pt4_point", 8'(point),       8'd4);
        chk("pt4_valid", 8'(point_valid), 8'd1);
        roll(2);
        chk("pt4_sum5",  8'(sum),         8'd5);
        chk("pt4_stay",  8'(win | lose),  8'd0);
        roll(3);
        chk("pt4_out_die1", 8'(die1), 8'd6);
        chk("pt4_out_sum",  8'(sum),  8'd7);
        chk("pt4_out_lose", 8'(lose), 8'd1);

        // Full 36-position period brings the pair back to make the point.
        do_reset();
        roll(3);
        roll(37);
        chk("period_die1", 8'(die1), 8'd3);
        chk("period_die2", 8'(die2), 8'd1);
        chk("period_win",  8'(win),  8'd1);

        // Reset beats new_game mid-roll.
        do_reset();
        roll(3);
        cycle(1'b1, 1'b0, 1'b0);
        chk("roll2_active", 8'(roll_active), 8'd1);
        cycle(1'b1, 1'b1, 1'b1);
        chk("rst_over_die1",  8'(die1),        8'd1);
        chk("rst_over_point", 8'(point),       8'd0);
        chk("rst_over_roll",  8'(roll_active), 8'd0);

        // Abort from POINT keeps the score.
        roll(6);
        cycle(1'b0, 1'b1, 1'b0);
        roll(3);
        chk("abort_pre_valid", 8'(point_valid), 8'd1);
        cycle(1'b0, 1'b1, 1'b0);
        chk("abort_valid", 8'(point_valid), 8'd0);
        chk("abort_wins",  8'(wins),        8'(SCORE_EN ? 1 : 0));

        // Four straight wins to push the 2-bit counter into saturation.
        do_reset();
        roll(6);
        repeat (3) begin
            cycle(1'b0, 1'b1, 1'b0);
            roll(1);
        end
        chk("sat_wins", 8'(wins), 8'(SCORE_EN ? SMAX : 0));

        // Random button traffic.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3,
                  $urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
